// File: rtl/sram_pkg.sv
// Shared types and default parameters for the 32-bit-to-16-bit SRAM bridge.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_SRAM_AW     = 18;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request bus. Handshake: a request (mem_read | mem_write) is held
// stable by the MEM stage while ready=0; it completes in the cycle ready=1.
interface sram_controller_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        ready;

    modport master (
        output mem_read, mem_write, address, data_write,
        input  data_read, ready
    );

    modport slave (
        input  mem_read, mem_write, address, data_write,
        output data_read, ready
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Phase wait counter: counts 0..WAIT_CYCLES-1 and flags the last cycle of a phase.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic last
);

    localparam int unsigned   CW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_V = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == LAST_V);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || last) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two
// halfword phases (LO then HI); ready freezes the pipeline while low.
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_controller_if.slave   mem,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output state_e             dbg_state
);

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [SRAM_AW-2:0]  idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [15:0]         dq_out_q, dq_out_d;

    logic                req;
    logic [SRAM_AW-2:0]  req_idx;
    logic                phase_last;
    logic                cnt_clear;

    assign req = mem.mem_read | mem.mem_write;
    // Out-of-range addresses simply wrap onto the SRAM by truncation.
    assign req_idx = (SRAM_AW-1)'((mem.address - 32'(BASE_ADDR)) >> 2);

    assign cnt_clear = (state_d != state_q) || !((state_q == LO) || (state_q == HI));

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .last  (phase_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req)        state_d = LO;
            LO:      if (phase_last) state_d = HI;
            HI:      if (phase_last) state_d = DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Address and write data load only on phase entry so they hold for the whole phase.
    always_comb begin
        write_d  = write_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        if ((state_q == IDLE) && req) begin
            write_d  = mem.mem_write;
            idx_d    = req_idx;
            wdata_d  = mem.data_write;
            addr_d   = {req_idx, 1'b0};
            dq_out_d = mem.mem_write ? mem.data_write[15:0] : 16'h0000;
        end
        if ((state_q == LO) && phase_last) begin
            addr_d   = {idx_q, 1'b1};
            dq_out_d = write_q ? wdata_q[31:16] : 16'h0000;
            if (!write_q) rdata_d[15:0] = sram_dq_in;
        end
        if ((state_q == HI) && phase_last && !write_q) rdata_d[31:16] = sram_dq_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
        end else begin
            write_q  <= write_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset releases we_n at once.
    always_comb begin
        sram_dq_oe    = ((state_q == LO) || (state_q == HI)) && write_q;
        sram_we_n     = !sram_dq_oe;
        mem.ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
        mem.data_read = ((state_q == DONE) && !write_q) ? rdata_q : 32'h0;
    end

    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table, reset-abort and W=1 back-to-back
// sequences, then random traffic against a word-level memory model.
module tb_sram_controller;
    import sram_pkg::*;

    localparam int AW      = 18;
    localparam int W2      = 2;
    localparam int W1      = 1;
    localparam int BASE    = 1024;
    localparam int IDX_MOD = 1 << (AW - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_controller_if bus();
    sram_controller_if bus1();

    logic [AW-1:0] sram_addr, sram_addr1;
    logic [15:0]   dq_out, dq_out1, dq_in, dq_in1;
    logic          dq_oe, dq_oe1, we_n, we_n1;
    state_e        st, st1;

    sram_controller #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W2)) dut (
        .clk(clk), .rst_n(rst_n), .mem(bus),
        .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_in(dq_in),
        .sram_dq_oe(dq_oe), .sram_we_n(we_n), .dbg_state(st)
    );

    sram_controller #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem(bus1),
        .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
        .sram_dq_oe(dq_oe1), .sram_we_n(we_n1), .dbg_state(st1)
    );

    // Asynchronous SRAM models: combinational read, write sampled on the clock.
    logic [15:0] sram0 [0:(1<<AW)-1];
    logic [15:0] sram1 [0:(1<<AW)-1];
    always @(posedge clk) if (!we_n)  sram0[sram_addr]  <= dq_out;
    always @(posedge clk) if (!we_n1) sram1[sram_addr1] <= dq_out1;
    assign dq_in  = sram0[sram_addr];
    assign dq_in1 = sram1[sram_addr1];

    // Scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] ref_mem [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned word_idx(input logic [31:0] a);
        int unsigned off;
        off = a - 32'(BASE);
        return (off >> 2) % IDX_MOD;
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    typedef struct {
        int            stall;
        logic [AW-1:0] lo_addr;
        logic [AW-1:0] hi_addr;
        logic [15:0]   lo_dq;
        logic [15:0]   hi_dq;
        logic [31:0]   rdata;
        bit            we_ok;
        bit            stable_ok;
    } obs_t;

    typedef struct {
        bit            rd;
        bit            wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [AW-1:0] exp_lo_addr;
        logic [15:0]   exp_lo_dq;
        logic [15:0]   exp_hi_dq;
        logic [31:0]   exp_rdata;
    } vec_t;

    // Drives one request on the W=2 instance and records what the SRAM side did.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, output obs_t o);
        bit seen_lo, seen_hi;
        int cyc;
        seen_lo = 0; seen_hi = 0; cyc = 0;
        o.stall = 0; o.lo_addr = '0; o.hi_addr = '0; o.lo_dq = '0; o.hi_dq = '0;
        o.rdata = '0; o.we_ok = 1; o.stable_ok = 1;
        @(negedge clk);
        bus.mem_read = rd; bus.mem_write = wr; bus.address = a; bus.data_write = d;
        #1;
        while (bus.ready !== 1'b1 && cyc < 40) begin
            if (st == LO || st == HI) begin
                if (we_n !== !wr || dq_oe !== wr) o.we_ok = 0;
                if (st == LO && !seen_lo) begin
                    seen_lo = 1; o.lo_addr = sram_addr; o.lo_dq = dq_out;
                end else if (st == HI && !seen_hi) begin
                    seen_hi = 1; o.hi_addr = sram_addr; o.hi_dq = dq_out;
                end else if (st == LO && (sram_addr !== o.lo_addr || dq_out !== o.lo_dq)) begin
                    o.stable_ok = 0;
                end else if (st == HI && (sram_addr !== o.hi_addr || dq_out !== o.hi_dq)) begin
                    o.stable_ok = 0;
                end
            end
            o.stall++;
            cyc++;
            @(negedge clk); #1;
        end
        check("ready_within_bound", 32'(cyc < 40), 32'd1);
        o.rdata = bus.data_read;
        bus.mem_read = 0; bus.mem_write = 0;
    endtask

    task automatic check_txn(input string p, input bit wr, input logic [AW-1:0] exp_lo,
                             input logic [15:0] exp_lo_dq, input logic [15:0] exp_hi_dq,
                             input logic [31:0] exp_rd, input obs_t o);
        check({p, "_stall"}, 32'(o.stall), 32'(2 * W2 + 1));
        check({p, "_lo_addr"}, 32'(o.lo_addr), 32'(exp_lo));
        check({p, "_hi_addr"}, 32'(o.hi_addr), 32'(exp_lo) + 32'd1);
        check({p, "_strobes"}, 32'(o.we_ok), 32'd1);
        check({p, "_stable"}, 32'(o.stable_ok), 32'd1);
        check({p, "_data_read"}, o.rdata, exp_rd);
        if (wr) begin
            check({p, "_lo_dq"}, 32'(o.lo_dq), 32'(exp_lo_dq));
            check({p, "_hi_dq"}, 32'(o.hi_dq), 32'(exp_hi_dq));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[9];
        obs_t          o;
        int            cyc;
        int            p;
        logic [31:0]   a, d, old_word;
        int unsigned   idx;
        bit            rd, wr;
        state_e        exp_st;

        bus.mem_read = 0;  bus.mem_write = 0;  bus.address = '0;  bus.data_write = '0;
        bus1.mem_read = 0; bus1.mem_write = 0; bus1.address = '0; bus1.data_write = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram0[i] <= '0;
            sram1[i] <= '0;
        end
        sram1[10] <= 16'h1111;
        sram1[11] <= 16'h2222;

        vecs[0] = '{0, 1, 32'd1024,   32'hDEADBEEF, 18'd0,       16'hBEEF, 16'hDEAD, 32'h0};
        vecs[1] = '{1, 0, 32'd1024,   32'h0,        18'd0,       16'h0,    16'h0,    32'hDEADBEEF};
        vecs[2] = '{0, 1, 32'd1036,   32'h0BADF00D, 18'd6,       16'hF00D, 16'h0BAD, 32'h0};
        vecs[3] = '{1, 1, 32'd1028,   32'h12345678, 18'd2,       16'h5678, 16'h1234, 32'h0};
        vecs[4] = '{1, 0, 32'd1028,   32'h0,        18'd2,       16'h0,    16'h0,    32'h12345678};
        vecs[5] = '{1, 0, 32'd1036,   32'h0,        18'd6,       16'h0,    16'h0,    32'h0BADF00D};
        vecs[6] = '{0, 1, 32'd525312, 32'hCAFEF00D, 18'd0,       16'hF00D, 16'hCAFE, 32'h0};
        vecs[7] = '{1, 0, 32'd1024,   32'h0,        18'd0,       16'h0,    16'h0,    32'hCAFEF00D};
        vecs[8] = '{1, 0, 32'd1020,   32'h0,        18'h3FFFE,   16'h0,    16'h0,    32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_dq_oe", 32'(dq_oe), 32'd0);
        check("rst_data_read", bus.data_read, 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(dq_out), 32'd0);
        check("rst_state", 32'(st), 32'(IDLE));
        bus.mem_read = 1; #1;
        check("rst_ready_with_req", 32'(bus.ready), 32'd0);
        bus.mem_read = 0;
        @(negedge clk); rst_n = 1;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, o);
            check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].exp_lo_addr,
                      vecs[i].exp_lo_dq, vecs[i].exp_hi_dq, vecs[i].exp_rdata, o);
            if (vecs[i].wr) ref_mem[word_idx(vecs[i].addr)] = vecs[i].wdata;
        end

        // Reset during the HI phase of a write
        @(negedge clk);
        bus.mem_write = 1; bus.address = 32'd1040; bus.data_write = 32'hAAAA5555;
        cyc = 0;
        while (st !== HI && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_hi", 32'(st), 32'(HI));
        rst_n = 0; #1;
        check("abort_we_n", 32'(we_n), 32'd1);
        check("abort_dq_oe", 32'(dq_oe), 32'd0);
        check("abort_state", 32'(st), 32'(IDLE));
        check("abort_ready_req", 32'(bus.ready), 32'd0);
        bus.mem_write = 0; #1;
        check("abort_ready_noreq", 32'(bus.ready), 32'd1);
        @(negedge clk); rst_n = 1;
        old_word = ref_read(word_idx(32'd1040));
        ref_mem[word_idx(32'd1040)] = {old_word[31:16], 16'h5555};
        access(1, 0, 32'd1040, 32'h0, o);
        check_txn("abort_readback", 0, 18'd8, 16'h0, 16'h0, 32'h00005555, o);

        // W=1 back-to-back reads with the request held
        @(negedge clk);
        bus1.mem_read = 1; bus1.address = 32'd1044;
        for (int i = 0; i < 12; i++) begin
            #1;
            p = i % (2 * W1 + 2);
            exp_st = (p == 0) ? IDLE : (p == 1) ? LO : (p == 2) ? HI : DONE;
            check($sformatf("w1_state_c%0d", i), 32'(st1), 32'(exp_st));
            check($sformatf("w1_ready_c%0d", i), 32'(bus1.ready), 32'(p == 2 * W1 + 1));
            if (p == 2 * W1 + 1)
                check($sformatf("w1_data_c%0d", i), bus1.data_read, 32'h22221111);
            @(negedge clk);
        end
        bus1.mem_read = 0;

        // Random traffic against the word-level model
        for (int n = 0; n < 30; n++) begin
            p  = $urandom_range(0, 3);
            rd = (p != 2);
            wr = (p >= 2);
            if ($urandom_range(0, 4) == 0) a = $urandom() & 32'hFFFF_FFFC;
            else                           a = 32'(BASE) + 32'(4 * $urandom_range(0, 15));
            d   = $urandom();
            idx = word_idx(a);
            access(rd, wr, a, d, o);
            check_txn($sformatf("rnd%0d", n), wr, AW'(idx * 2), d[15:0], d[31:16],
                      wr ? 32'h0 : ref_read(idx), o);
            if (wr) ref_mem[idx] = d;
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle bridge between the MEM stage and an external 16-bit asynchronous SRAM; it replaces the single-cycle on-chip data memory. It accepts the same 32-bit read/write requests the MEM stage already issues. Each 32-bit word is split into two 16-bit SRAM accesses. `ready` is the pipeline freeze signal: the pipeline stalls while it is low.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM halfword address width.
- `WAIT_CYCLES`, 2: cycles each SRAM phase is held (≥1).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: read request from MEM stage.
- `mem_write` in 1: write request from MEM stage.
- `address` in 32: byte address.
- `data_write` in 32: store data.
- `data_read` out 32: load data.
- `ready` out 1: request complete / pipeline may advance.
- `sram_addr` out SRAM_AW: halfword address.
- `sram_dq_out` out 16: write data to SRAM.
- `sram_dq_in` in 16: read data from SRAM.
- `sram_dq_oe` out 1: 1 = controller drives the data bus.
- `sram_we_n` out 1: active-low SRAM write enable.

## Operation
- Word index = `(address - BASE_ADDR) >> 2`, truncated to SRAM_AW-1 bits. Out-of-range addresses wrap modulo SRAM size; no error is raised.
- Halfword address: LO phase = `{index, 0}`, HI phase = `{index, 1}`.
- Request = `mem_read | mem_write`. When both are set, the request is a write.
- FSM states:
  - IDLE: on request, latch address, data and op, then go to LO.
  - LO: hold WAIT_CYCLES cycles, then go to HI.
  - HI: hold WAIT_CYCLES cycles, then go to DONE.
  - DONE: unconditionally go to IDLE.
- Write path:
  - LO drives `data_write[15:0]`, HI drives `data_write[31:16]`.
  - `sram_dq_oe=1` and `sram_we_n=0` for every cycle of LO/HI.
- Read path:
  - `sram_dq_oe=0` and `sram_we_n=1`.
  - `sram_dq_in` is sampled on the last cycle of LO into bits [15:0] and on the last cycle of HI into bits [31:16] of an internal read register.
- `ready` = (IDLE and no request) or DONE. It is combinational from state and the request inputs.
- `data_read` = read register when in DONE with a latched read, otherwise 0.
- The MEM stage holds its request inputs stable while `ready=0`. The controller uses only its latched copies after IDLE.
- A wait counter counts 0..WAIT_CYCLES-1 within each phase and clears on every phase entry.

## Timing
- Reset values:
  - state = IDLE, counter = 0, read register = 0, latched op/addr/data = 0.
  - `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_out=0`, `data_read=0`.
  - `ready=1` if no request is present.
- Reset asserted mid-access aborts the access immediately (asynchronously):
  - `sram_we_n` rises at once.
  - A partial write may leave only the low halfword updated; this is accepted.
- Latency with W = WAIT_CYCLES, request first seen in cycle 0:
  - cycle 0 is IDLE with `ready=0`;
  - cycles 1..W are LO;
  - cycles W+1..2W are HI;
  - cycle 2W+1 is DONE with `ready=1`.
  - Total stall is 2W+1 cycles. Default W=2 gives 5 cycles.
- Back-to-back requests: the pipeline advances on the DONE edge. The next request is seen in IDLE on the following cycle, so there is one idle cycle between accesses.
- `sram_addr` and `sram_dq_out` are registered and change only on phase entry, so they are stable throughout each phase.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the default localparams for BASE_ADDR, SRAM_AW and WAIT_CYCLES.
- One sub-module is natural: `sram_wait_counter`. It takes clk, rst_n, clear and a WAIT_CYCLES parameter, and outputs `last`.
- FSM, latches and datapath stay in `sram_controller`.

## Test plan
- Reset: assert `rst_n=0` with no request -> `ready=1`, `sram_we_n=1`, `sram_dq_oe=0`, `data_read=0`.
- Write then read, W=2:
  - write `address=1024`, `data_write=32'hDEADBEEF` -> `sram_addr=0`/`16'hBEEF` for 2 cycles, then `sram_addr=1`/`16'hDEAD` for 2 cycles, `ready=1` at cycle 5;
  - a read of 1024 against an SRAM model -> `data_read=32'hDEADBEEF` in DONE.
- Address mapping: write `address=1036` -> `sram_addr` values 6 then 7.
- Read and write both asserted at `address=1028`, `data_write=32'h12345678` -> treated as write. A following read returns `32'h12345678`, and `data_read` is 0 during the write's DONE.
- Reset in HI of a write to 1040 with `data_write=32'hAAAA5555` -> `sram_we_n=1` immediately, state IDLE, `ready` follows the request. A later read of 1040 returns low half `16'h5555`.
- W=1, back-to-back reads with the request held by the pipeline -> each read stalls 3 cycles, with exactly one IDLE cycle between DONE and the next LO.
